// File: rtl/tlut_acc_pkg.sv
// -----------------------------------------------------------------------------
// tlut_acc_pkg
// Shared definitions for the weight-stream accumulator:
//   - state_e       : control FSM states (IDLE / ACCUM / DONE)
//   - *_DEF         : default widths used by acc_weight_stream and acc_lane
// -----------------------------------------------------------------------------
package tlut_acc_pkg;

    localparam int DIM_C_DEF        = 16;
    localparam int WEIGHT_WIDTH_DEF = 8;
    localparam int ACC_WIDTH_DEF    = 24;
    localparam int CNT_WIDTH_DEF    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage : tlut_acc_pkg

// File: rtl/acc_lane.sv
// -----------------------------------------------------------------------------
// acc_lane
// One accumulation channel: extends the input (sign or zero), adds it to the
// running sum, detects overflow and keeps a sticky overflow flag.
// Build option: define ACC_WEIGHT_SAT_EN to clamp overflowing adds to the
// representable max/min; otherwise the sum wraps modulo 2^ACC_WIDTH.
//
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   zero_i     : clear sum and overflow flag (new window or abort)
//   add_i      : accept one beat (add val_i to the sum)
//   signed_i   : 1 = two's-complement input and sum, 0 = unsigned
//   val_i      : channel input value
//   sum_o      : registered running sum
//   ovf_o      : sticky overflow flag
// -----------------------------------------------------------------------------
module acc_lane
    import tlut_acc_pkg::*;
#(
    parameter int WEIGHT_WIDTH = WEIGHT_WIDTH_DEF,
    parameter int ACC_WIDTH    = ACC_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    zero_i,
    input  logic                    add_i,
    input  logic                    signed_i,
    input  logic [WEIGHT_WIDTH-1:0] val_i,
    output logic [ACC_WIDTH-1:0]    sum_o,
    output logic                    ovf_o
);

    logic [ACC_WIDTH-1:0] sum_q, sum_d;
    logic                 ovf_q, ovf_d;
    logic [ACC_WIDTH-1:0] ext;
    logic [ACC_WIDTH:0]   raw;
    logic                 add_ovf;
`ifdef ACC_WEIGHT_SAT_EN
    logic [ACC_WIDTH-1:0] sat_val;
`endif

    always_comb begin
        ext = {{(ACC_WIDTH-WEIGHT_WIDTH){signed_i & val_i[WEIGHT_WIDTH-1]}}, val_i};
        raw = {1'b0, sum_q} + {1'b0, ext};
        // Signed overflow: operands agree in sign but the result does not.
        // Unsigned overflow: carry out of the top bit.
        if (signed_i) begin
            add_ovf = (sum_q[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) &&
                      (raw[ACC_WIDTH-1] != sum_q[ACC_WIDTH-1]);
        end else begin
            add_ovf = raw[ACC_WIDTH];
        end
`ifdef ACC_WEIGHT_SAT_EN
        // Signed overflow direction follows the (shared) operand sign;
        // unsigned overflow can only go upward.
        if (signed_i) begin
            sat_val = sum_q[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                         : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end else begin
            sat_val = '1;
        end
`endif

        // NOTE: every next-state signal gets a default first so the
        // combinational block never infers a latch on an untaken branch.
        sum_d = sum_q;
        ovf_d = ovf_q;
        if (zero_i) begin
            sum_d = '0;
            ovf_d = 1'b0;
        end else if (add_i) begin
`ifdef ACC_WEIGHT_SAT_EN
            sum_d = add_ovf ? sat_val : raw[ACC_WIDTH-1:0];
`else
            sum_d = raw[ACC_WIDTH-1:0];
`endif
            ovf_d = ovf_q | add_ovf;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            ovf_q <= ovf_d;
        end
    end

    assign sum_o = sum_q;
    assign ovf_o = ovf_q;

endmodule : acc_lane

// File: rtl/acc_weight_stream.sv
// -----------------------------------------------------------------------------
// acc_weight_stream
// Windowed multi-channel accumulator. A start in IDLE latches the window
// length and signedness, zeroes all lanes and opens an accumulation window;
// each accepted beat adds in_val into DIM_C independent acc_lane instances.
// After the last beat the result is presented with out_valid until the
// consumer takes it; start together with out_ready opens the next window
// with no idle cycle. clear aborts everything synchronously.
// Build option: ACC_WEIGHT_SAT_EN (saturating lanes, see acc_lane).
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   clear               : synchronous abort to IDLE with all state zeroed
//   start               : open a window (IDLE, or DONE with out_ready)
//   cfg_len, cfg_signed : window length in beats / signed mode, taken on start
//   in_valid, in_ready  : input beat handshake
//   in_val              : per-channel input values
//   out_valid, out_ready: result handshake
//   out_sum             : per-channel registered sums
//   ovf                 : per-channel sticky overflow flags
//   busy                : high whenever not IDLE
// -----------------------------------------------------------------------------
module acc_weight_stream
    import tlut_acc_pkg::*;
#(
    parameter int DIM_C        = DIM_C_DEF,
    parameter int WEIGHT_WIDTH = WEIGHT_WIDTH_DEF,
    parameter int ACC_WIDTH    = ACC_WIDTH_DEF,
    parameter int CNT_WIDTH    = CNT_WIDTH_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 clear,
    input  logic                                 start,
    input  logic [CNT_WIDTH-1:0]                 cfg_len,
    input  logic                                 cfg_signed,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [DIM_C-1:0][WEIGHT_WIDTH-1:0]   in_val,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [DIM_C-1:0][ACC_WIDTH-1:0]      out_sum,
    output logic [DIM_C-1:0]                     ovf,
    output logic                                 busy
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_e               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] len_q;
    logic                 signed_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic                 busy_q;

    logic start_ok;
    logic beat_ok;
    logic last_beat;
    logic lane_zero;

    always_comb begin
        // start is honoured only in IDLE, or in DONE while the result is taken.
        start_ok  = !clear && start &&
                    ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
        beat_ok   = !clear && in_valid && in_ready_q;
        last_beat = beat_ok && (cnt_q == (len_q - CNT_ONE));
        lane_zero = clear || start_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            signed_q    <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (clear) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (start_ok) begin
            len_q    <= cfg_len;
            signed_q <= cfg_signed;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            if (cfg_len == '0) begin
                // Empty window: present the zeroed sums immediately.
                state_q     <= ST_DONE;
                in_ready_q  <= 1'b0;
                out_valid_q <= 1'b1;
            end else begin
                state_q     <= ST_ACCUM;
                in_ready_q  <= 1'b1;
                out_valid_q <= 1'b0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_ACCUM: begin
                    if (beat_ok) begin
                        cnt_q <= cnt_q + CNT_ONE;
                        if (last_beat) begin
                            state_q     <= ST_DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    for (genvar c = 0; c < DIM_C; c++) begin : g_lane
        acc_lane #(
            .WEIGHT_WIDTH (WEIGHT_WIDTH),
            .ACC_WIDTH    (ACC_WIDTH)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .zero_i   (lane_zero),
            .add_i    (beat_ok),
            .signed_i (signed_q),
            .val_i    (in_val[c]),
            .sum_o    (out_sum[c]),
            .ovf_o    (ovf[c])
        );
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule : acc_weight_stream

// File: tb/tb_acc_weight_stream.sv
// -----------------------------------------------------------------------------
// tb_acc_weight_stream
// Self-checking bench for acc_weight_stream with a narrow accumulator so that
// overflow is reachable. The reference model keeps each channel's sum as a
// plain integer and applies range limits (wrap, or clamp when
// ACC_WEIGHT_SAT_EN is defined).
// -----------------------------------------------------------------------------
module tb_acc_weight_stream;

    localparam int DIM = 4;
    localparam int WW  = 8;
    localparam int AW  = 10;
    localparam int CW  = 8;

    typedef logic [DIM-1:0][WW-1:0] vec_t;

    logic                   clk;
    logic                   rst_n;
    logic                   clear;
    logic                   start;
    logic [CW-1:0]          cfg_len;
    logic                   cfg_signed;
    logic                   in_valid;
    logic                   in_ready;
    vec_t                   in_val;
    logic                   out_valid;
    logic                   out_ready;
    logic [DIM-1:0][AW-1:0] out_sum;
    logic [DIM-1:0]         ovf;
    logic                   busy;

    int checks   = 0;
    int failures = 0;

    int exp_sum [DIM];
    bit exp_ovf [DIM];
    bit cur_sgn;

    acc_weight_stream #(
        .DIM_C        (DIM),
        .WEIGHT_WIDTH (WW),
        .ACC_WIDTH    (AW),
        .CNT_WIDTH    (CW)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .start      (start),
        .cfg_len    (cfg_len),
        .cfg_signed (cfg_signed),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_val     (in_val),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .ovf        (ovf),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int step(input int acc, input logic [WW-1:0] v, input bit sgn,
                                output bit o);
        int x, s, lo, hi, span;
        span = 1 << AW;
        if (sgn) begin
            x  = $signed(v);
            lo = -(span / 2);
            hi = span / 2 - 1;
        end else begin
            x  = int'(v);
            lo = 0;
            hi = span - 1;
        end
        s = acc + x;
        o = (s > hi) || (s < lo);
`ifdef ACC_WEIGHT_SAT_EN
        if (s > hi) s = hi;
        if (s < lo) s = lo;
`else
        if (s > hi) s = s - span;
        if (s < lo) s = s + span;
`endif
        return s;
    endfunction

    function automatic logic [AW-1:0] to_bits(input int v);
        logic [31:0] t;
        t = v;
        return t[AW-1:0];
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int c = 0; c < DIM; c++) v[c] = WW'($urandom);
        return v;
    endfunction

    function automatic vec_t splat(input logic [WW-1:0] b);
        vec_t v;
        for (int c = 0; c < DIM; c++) v[c] = b;
        return v;
    endfunction

    task automatic model_zero();
        for (int c = 0; c < DIM; c++) begin
            exp_sum[c] = 0;
            exp_ovf[c] = 1'b0;
        end
    endtask

    task automatic model_beat(input vec_t v);
        bit o;
        for (int c = 0; c < DIM; c++) begin
            exp_sum[c] = step(exp_sum[c], v[c], cur_sgn, o);
            exp_ovf[c] = exp_ovf[c] | o;
        end
    endtask

    task automatic check_sums(input string tag);
        logic [DIM-1:0] eo;
        for (int c = 0; c < DIM; c++) begin
            check($sformatf("%s_sum%0d", tag, c), 64'(out_sum[c]), 64'(to_bits(exp_sum[c])));
            eo[c] = exp_ovf[c];
        end
        check({tag, "_ovf"}, 64'(ovf), 64'(eo));
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic begin_window(input int len, input bit sgn);
        cfg_len    = CW'(len);
        cfg_signed = sgn;
        start      = 1'b1;
        tick();
        start   = 1'b0;
        cur_sgn = sgn;
        model_zero();
        check("start_busy", 64'(busy), 64'(1));
        if (len == 0) check("zlen_valid", 64'(out_valid), 64'(1));
        else          check("start_rdy", 64'(in_ready), 64'(1));
    endtask

    // Idle gap cycles carry garbage data and ignored start requests.
    task automatic feed(input vec_t v, input int gap);
        repeat (gap) begin
            in_valid   = 1'b0;
            in_val     = rand_vec();
            start      = 1'($urandom);
            cfg_len    = CW'($urandom);
            cfg_signed = 1'($urandom);
            tick();
        end
        start = 1'b0;
        check("accum_ov", 64'(out_valid), 64'(0));
        check("accum_rdy", 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        in_val   = v;
        tick();
        in_valid = 1'b0;
        in_val   = rand_vec();
        model_beat(v);
    endtask

    task automatic finish_window(input int stall, input bit b2b, input int nlen, input bit nsgn);
        check("done_valid", 64'(out_valid), 64'(1));
        check("done_rdy", 64'(in_ready), 64'(0));
        check_sums("done");
        repeat (stall) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom);
            in_val    = rand_vec();
            start     = 1'($urandom);
            cfg_len   = CW'($urandom_range(0, 8));
            tick();
            check("stall_valid", 64'(out_valid), 64'(1));
            check("stall_rdy", 64'(in_ready), 64'(0));
            check_sums("stall");
        end
        in_valid   = 1'b0;
        start      = b2b;
        cfg_len    = CW'(nlen);
        cfg_signed = nsgn;
        out_ready  = 1'b1;
        tick();
        start     = 1'b0;
        out_ready = 1'b0;
        if (b2b) begin
            cur_sgn = nsgn;
            model_zero();
            check_sums("b2b");
            check("b2b_busy", 64'(busy), 64'(1));
            if (nlen == 0) check("b2b_zvalid", 64'(out_valid), 64'(1));
            else begin
                check("b2b_rdy", 64'(in_ready), 64'(1));
                check("b2b_ov", 64'(out_valid), 64'(0));
            end
        end else begin
            check("idle_ov", 64'(out_valid), 64'(0));
            check("idle_busy", 64'(busy), 64'(0));
            check_sums("retain");
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vec_t v;
        int   len, nlen;
        bit   sgn, nsgn, b2b, active;

        rst_n = 1'b0; clear = 1'b0; start = 1'b0; cfg_len = '0; cfg_signed = 1'b0;
        in_valid = 1'b0; in_val = '0; out_ready = 1'b0;
        model_zero();
        cur_sgn = 1'b0;
        #12;
        check("rst_ov", 64'(out_valid), 64'(0));
        check("rst_rdy", 64'(in_ready), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check_sums("rst");
        rst_n = 1'b1;
        tick();

        // Unsigned window 3,5,7,9 on all channels -> 24.
        begin_window(4, 1'b0);
        feed(splat(8'd3), 0);
        feed(splat(8'd5), 0);
        feed(splat(8'd7), 0);
        feed(splat(8'd9), 0);
        check("uns_sum0", 64'(out_sum[0]), 64'(24));
        finish_window(0, 1'b0, 0, 1'b0);

        // Signed window: channel 0 gets -1, -2, +5 -> 2.
        begin_window(3, 1'b1);
        v = rand_vec(); v[0] = 8'hFF; feed(v, 0);
        v = rand_vec(); v[0] = 8'hFE; feed(v, 0);
        v = rand_vec(); v[0] = 8'h05; feed(v, 0);
        check("sgn_sum0", 64'(out_sum[0]), 64'(2));
        finish_window(0, 1'b0, 0, 1'b0);

        // Input gaps and a 5-cycle output stall.
        begin_window(5, 1'b0);
        for (int b = 0; b < 5; b++) feed(rand_vec(), 2);
        finish_window(5, 1'b0, 0, 1'b0);

        // Five beats of 255 into a 10-bit unsigned sum.
        begin_window(5, 1'b0);
        for (int b = 0; b < 5; b++) feed(splat(8'hFF), 0);
        check("ovf_all", 64'(ovf), 64'({DIM{1'b1}}));
`ifdef ACC_WEIGHT_SAT_EN
        check("ovf_sum0", 64'(out_sum[0]), 64'(1023));
`else
        check("ovf_sum0", 64'(out_sum[0]), 64'(251));
`endif
        finish_window(0, 1'b0, 0, 1'b0);

        // clear wins over start in IDLE.
        clear = 1'b1; start = 1'b1; cfg_len = CW'(3);
        tick();
        clear = 1'b0; start = 1'b0;
        model_zero();
        check("clr_start_busy", 64'(busy), 64'(0));
        check("clr_start_rdy", 64'(in_ready), 64'(0));

        // Abort after beat 2 of 4, then an empty window.
        begin_window(4, 1'b0);
        feed(rand_vec(), 0);
        feed(rand_vec(), 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_zero();
        check("clr_busy", 64'(busy), 64'(0));
        check("clr_rdy", 64'(in_ready), 64'(0));
        check("clr_ov", 64'(out_valid), 64'(0));
        check_sums("clr");
        begin_window(0, 1'b0);
        finish_window(1, 1'b0, 0, 1'b0);

        // Back-to-back windows.
        begin_window(2, 1'b0);
        feed(rand_vec(), 0);
        feed(rand_vec(), 0);
        finish_window(0, 1'b1, 3, 1'b1);
        for (int b = 0; b < 3; b++) feed(rand_vec(), 0);
        finish_window(0, 1'b0, 0, 1'b0);

        // Reset in the middle of a window.
        begin_window(4, 1'b0);
        feed(splat(8'd40), 0);
        feed(splat(8'd40), 0);
        rst_n = 1'b0;
        #2;
        model_zero();
        check("mrst_ov", 64'(out_valid), 64'(0));
        check("mrst_rdy", 64'(in_ready), 64'(0));
        check("mrst_busy", 64'(busy), 64'(0));
        check_sums("mrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            in_valid = 1'b1;
            in_val   = rand_vec();
            tick();
        end
        in_valid = 1'b0;
        check("post_rst_ov", 64'(out_valid), 64'(0));
        check("post_rst_busy", 64'(busy), 64'(0));
        check_sums("post_rst");

        // Randomized windows.
        active = 1'b0;
        len    = 0;
        sgn    = 1'b0;
        for (int w = 0; w < 40; w++) begin
            if (!active) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b1;
                    in_val   = rand_vec();
                    tick();
                    check("idle_rdy", 64'(in_ready), 64'(0));
                end
                check_sums("idle");
                len = $urandom_range(0, 8);
                sgn = 1'($urandom);
                begin_window(len, sgn);
            end
            for (int b = 0; b < len; b++) feed(rand_vec(), $urandom_range(0, 2));
            b2b  = (w != 39) && 1'($urandom);
            nlen = $urandom_range(0, 8);
            nsgn = 1'($urandom);
            finish_window($urandom_range(0, 3), b2b, nlen, nsgn);
            active = b2b;
            len    = nlen;
            sgn    = nsgn;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_acc_weight_stream
